// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It handles freeze-time redirect replay and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic [XLEN-1:0]  ex_redirect_pc,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   output logic             pc_stall,
   output logic             pc_redirect,
   output logic [XLEN-1:0]  pc_redirect_target,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_flush,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REPLAY = 2'd2} state_t;
   state_t state, state_nx;
   logic pend, pend_nx;
   logic [XLEN-1:0] pend_pc, pend_pc_nx;
   logic load_use, busy, live, redir, lu, ifw;
   always_comb begin
      load_use = ex_mem_read && ex_rd != 5'd0 &&
                 ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
      busy  = rst_n && dmem_busy;
      live  = rst_n && !dmem_busy;
      redir = live && (state == REPLAY || ex_redirect);
      lu    = live && !redir && load_use;
      ifw   = live && !redir && !load_use && !imem_ready;
      pc_stall     = busy || lu || ifw;
      pc_redirect  = redir;
      if_id_stall  = busy || lu;
      if_id_flush  = redir || ifw;
      id_ex_stall  = busy;
      id_ex_flush  = redir || lu;
      ex_mem_stall = busy;
      mem_wb_flush = busy;
      pc_redirect_target = !rst_n ? '0 : state == REPLAY ? pend_pc : ex_redirect_pc;
      ctrl_state = state;
      // a redirect seen during a freeze is remembered and replayed once memory is done
      state_nx   = dmem_busy ? (state == REPLAY ? REPLAY : MEM_WAIT) :
                   (state == MEM_WAIT && pend) ? REPLAY : RUN;
      pend_nx    = dmem_busy ? (pend || ex_redirect) : (pend && state != REPLAY);
      pend_pc_nx = (dmem_busy && ex_redirect) ? ex_redirect_pc : pend_pc;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         pend      <= 1'b0;
         pend_pc   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state   <= state_nx;
         pend    <= pend_nx;
         pend_pc <= pend_pc_nx;
         if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (pc_redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
   localparam logic [7:0] NONE  = 8'h00;
   localparam logic [7:0] LU    = 8'hA4;
   localparam logic [7:0] REDIR = 8'h54;
   localparam logic [7:0] FRZ   = 8'hAB;
   localparam logic [7:0] IFW   = 8'h90;
   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_busy;
   logic [31:0] ex_redirect_pc, pc_redirect_target;
   logic pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic ex_mem_stall, mem_wb_flush;
   logic [1:0] ctrl_state;
   logic [15:0] stall_cnt, flush_cnt;
   logic [15:0] es, ef;
   int n_chk, n_fail;
   typedef struct packed {
      logic [7:0]  ctl;
      logic [1:0]  st;
      logic [31:0] tgt;
   } exp_t;
   exp_t q[$];
   exp_t e;
   logic [7:0] ctl;

   pipeline_hazard_ctrl #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
      .imem_ready(imem_ready), .dmem_busy(dmem_busy), .pc_stall(pc_stall),
      .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
      .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
      .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
      .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_mem_read = 0; ex_redirect = 0; ex_redirect_pc = 0; imem_ready = 1; dmem_busy = 0;
   endtask

   task automatic set_lu();
      ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
   endtask

   // push expectation, compare on the falling edge, advance past the next rising edge
   task automatic step(input string tag, input logic [7:0] c, input logic [1:0] s,
                       input logic [31:0] t);
      q.push_back('{ctl: c, st: s, tgt: t});
      @(negedge clk);
      e = q.pop_front();
      ctl = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
             id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
      chk({tag, ".ctl"}, {24'd0, ctl}, {24'd0, e.ctl});
      chk({tag, ".state"}, {30'd0, ctrl_state}, {30'd0, e.st});
      chk({tag, ".target"}, pc_redirect_target, e.tgt);
      chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, es});
      chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, ef});
      chk({tag, ".nand_if_id"}, {31'd0, if_id_stall & if_id_flush}, 32'd0);
      if (rst_n && e.ctl[7] && es != 16'hFFFF) es = es + 1'b1;
      if (rst_n && e.ctl[6] && ef != 16'hFFFF) ef = ef + 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; es = 0; ef = 0;
      rst_n = 0;
      idle();
      set_lu(); dmem_busy = 1; ex_redirect = 1; ex_redirect_pc = 32'h44;
      step("in_reset", NONE, 2'd0, 32'h0);
      rst_n = 1;
      idle();
      step("idle", NONE, 2'd0, 32'h0);
      set_lu();
      step("lu_rs2", LU, 2'd0, 32'h0);
      idle();
      step("lu_gone", NONE, 2'd0, 32'h0);
      set_lu(); ex_rd = 0; id_rs2 = 0;
      step("lu_x0", NONE, 2'd0, 32'h0);
      set_lu(); id_use_rs2 = 0;
      step("lu_unused", NONE, 2'd0, 32'h0);
      idle(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
      step("lu_rs1", LU, 2'd0, 32'h0);
      idle(); set_lu(); ex_redirect = 1; ex_redirect_pc = 32'h100;
      step("redir_over_lu", REDIR, 2'd0, 32'h100);
      idle(); dmem_busy = 1; ex_redirect = 1; ex_redirect_pc = 32'h200;
      step("frz1", FRZ, 2'd0, 32'h200);
      ex_redirect = 0; ex_redirect_pc = 0;
      step("frz2", FRZ, 2'd1, 32'h0);
      step("frz3", FRZ, 2'd1, 32'h0);
      dmem_busy = 0;
      step("busy_fall", NONE, 2'd1, 32'h0);
      step("replay", REDIR, 2'd2, 32'h200);
      step("after_replay", NONE, 2'd0, 32'h0);
      dmem_busy = 1; ex_redirect = 1; ex_redirect_pc = 32'h300;
      step("ow1", FRZ, 2'd0, 32'h300);
      ex_redirect_pc = 32'h340;
      step("ow2", FRZ, 2'd1, 32'h340);
      dmem_busy = 0; ex_redirect = 0; ex_redirect_pc = 0;
      step("ow_fall", NONE, 2'd1, 32'h0);
      dmem_busy = 1; ex_redirect_pc = 32'h77;
      step("replay_busy", FRZ, 2'd2, 32'h340);
      dmem_busy = 0;
      step("ow_replay", REDIR, 2'd2, 32'h340);
      ex_redirect_pc = 0;
      step("ow_run", NONE, 2'd0, 32'h0);
      imem_ready = 0;
      step("ifw1", IFW, 2'd0, 32'h0);
      step("ifw2", IFW, 2'd0, 32'h0);
      set_lu();
      step("lu_over_ifw", LU, 2'd0, 32'h0);
      idle(); dmem_busy = 1; ex_redirect = 1; ex_redirect_pc = 32'h500;
      step("rfrz1", FRZ, 2'd0, 32'h500);
      ex_redirect = 0; ex_redirect_pc = 0;
      step("rfrz2", FRZ, 2'd1, 32'h0);
      rst_n = 0; es = 0; ef = 0;
      step("rst_mid", NONE, 2'd0, 32'h0);
      dmem_busy = 0; rst_n = 1;
      step("rst_rel1", NONE, 2'd0, 32'h0);
      step("rst_rel2", NONE, 2'd0, 32'h0);
      set_lu();
      repeat (16'hFFFE - es) @(posedge clk);
      #1;
      es = 16'hFFFE;
      step("sat1", LU, 2'd0, 32'h0);
      step("sat2", LU, 2'd0, 32'h0);
      step("sat3", LU, 2'd0, 32'h0);
      idle();
      step("sat_hold", NONE, 2'd0, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
